scroll_banner_ctrl: RTL and testbench
=====================================

// Module: scroll_banner_ctrl
// PURPOSE
//  Parametrised scrolling hex banner for multiplexed 7-segment displays. Holds an N_MSG-digit message
//  and scrolls a window of it across N_DISP digits at a programmable rate. Modes: wrap (rotate) or bounce.
//  Supports run-time message reload. Top-level display driver on the board.
// PARAMETERS
//  N_MSG       10          message length in hex digits (>= N_DISP, elaboration error otherwise)
//  N_DISP      4           physical display digits
//  TICK_DIV    25_000_000  clk cycles per scroll step (>= 2)
//  REFRESH_DIV 50_000      clk cycles each digit is lit during multiplexing (>= 1)
// PORTS
//  clk         in   1          system clock, all state on rising edge
//  reset       in   1          asynchronous, active-high; clears all state
//  en          in   1          1 = scroll prescaler runs; 0 = freeze position (display still refreshes)
//  dir         in   1          wrap mode: 0 = pos increments, 1 = pos decrements
//  mode        in   1          0 = wrap, 1 = bounce
//  load        in   1          1-cycle strobe: capture msg into message register
//  msg         in   4*N_MSG    message; digit k = msg[4k+3:4k]
//  an          out  N_DISP     anode enables, active-low, one-hot-low
//  sseg        out  7          segments {g,f,e,d,c,b,a}, active-low
//  pos         out  $clog2(N_MSG) current scroll offset
//  scroll_tick out  1          1-cycle pulse on every scroll step
// BEHAVIOUR
//  Reset: msg_reg=0, pos=0, bdir=0, prescaler=0, refresh cnt=0, digit idx=0, an=all 1s, sseg=7'h7F,
//   scroll_tick=0. First lit digit appears the cycle after reset deasserts.
//  Prescaler: counts 0..TICK_DIV-1 while en=1, holds while en=0. scroll_tick=1 on the cycle count==TICK_DIV-1
//   and en=1; pos updates on that same edge (registered, visible next cycle).
//  Wrap (mode=0): pos <= dir ? (pos==0 ? N_MSG-1 : pos-1) : (pos==N_MSG-1 ? 0 : pos+1).
//  Bounce (mode=1): range 0..PMAX, PMAX=N_MSG-N_DISP. bdir=0 -> pos+1, bdir=1 -> pos-1.
//   At pos==PMAX with bdir=0: bdir<=1, pos<=PMAX-1; at pos==0 with bdir=1: bdir<=0, pos<=1.
//   PMAX==0: pos stays 0, tick still pulses. dir ignored in bounce.
//   Mode switched to bounce while pos>PMAX: next step sets pos<=PMAX, bdir<=1.
//  Load: msg_reg<=msg, pos<=0, bdir<=0, prescaler<=0. load beats a coincident tick (no scroll_tick that cycle).
//   Refresh counter not disturbed by load.
//  Window: display digit i (i=0 rightmost, an[0]) shows msg_reg digit (pos+i) mod N_MSG.
//  Multiplex: refresh counter 0..REFRESH_DIV-1; on wrap idx <= (idx==N_DISP-1) ? 0 : idx+1.
//   an and sseg registered: an = ~(1<<idx), sseg = hex7seg(selected digit); both change on the same edge.
//  Hex encoding (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset asserted mid-scroll: immediate blanking (an all 1s) and state per reset list, independent of clk.
// STRUCTURE
//  Package banner_pkg: HEX7SEG[16] constant table, SSEG_BLANK=7'h7F, MODE_WRAP/MODE_BOUNCE constants.
//  Sub-module sseg_mux_drv (refresh counter, digit index, an/sseg registers, hex decode); top holds
//   msg_reg, prescaler, pos/bdir FSM and window digit selection.
// TESTING (bench params N_MSG=6, N_DISP=4, TICK_DIV=4, REFRESH_DIV=2)
//  1 reset held, msg=24'h654321 load -> an=4'hF, sseg=7'h7F, pos=0; after release an cycles E,D,B,7 every 2 clk.
//  2 wrap dir=0 en=1: scroll_tick every 4 clk; pos 0,1..5,0; at pos=5 digit0=6, digit1=1 (wrap of window).
//  3 wrap dir=1 from pos=0 -> next tick pos=5; en=0 for 20 clk -> no tick, pos held, an still cycles.
//  4 bounce: pos sequence 0,1,2,1,0,1 (PMAX=2); switch to bounce at pos=5 -> next pos=2, then 1.
//  5 load of 24'hABCDEF coincident with tick at pos=3 -> pos=0, no scroll_tick, digit0 shows F (sseg=7'h0E).
//  6 async reset pulse mid-refresh (between clk edges) -> an=4'hF, sseg=7'h7F immediately; pos=0, msg_reg=0.

Source files
------------

// File: rtl/scroll_banner_ctrl_pkg.sv
// Shared constants for the scrolling banner: hex-to-segment table,
// blank pattern and scroll mode encodings.
package banner_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex digit value.
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/scroll_banner_ctrl_if.sv
// Control and display bundle of the scrolling banner. The controller
// attaches through the slave modport, whoever drives it uses master.
interface scroll_banner_ctrl_if #(
  parameter int N_MSG  = 10,
  parameter int N_DISP = 4
);

  localparam int PW = (N_MSG > 1) ? $clog2(N_MSG) : 1;

  logic                 en;
  logic                 dir;
  logic                 mode;
  logic                 load;
  logic [4*N_MSG-1:0]   msg;
  logic [N_DISP-1:0]    an;
  logic [6:0]           sseg;
  logic [PW-1:0]        pos;
  logic                 scroll_tick;

  modport master (
    output en, dir, mode, load, msg,
    input  an, sseg, pos, scroll_tick
  );

  modport slave (
    input  en, dir, mode, load, msg,
    output an, sseg, pos, scroll_tick
  );

endinterface

// File: rtl/scroll_banner_ctrl_sseg_mux_drv.sv
// Display multiplexer: walks one digit at a time across the display,
// holding each for REFRESH_DIV clocks, and registers anode/segment drive.
module sseg_mux_drv
  import banner_pkg::*;
#(
  parameter int N_DISP      = 4,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*N_DISP-1:0] digits,
  output logic [N_DISP-1:0]   an,
  output logic [6:0]          sseg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DISP > 1) ? $clog2(N_DISP) : 1;
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_DISP - 1);

  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;

  // Refresh counter; the lit digit advances each time it wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RMAX) begin
      rcnt <= '0;
      idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Anode and segment registers update together so no ghosting occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      sseg <= SSEG_BLANK;
    end else begin
      an   <= ~(N_DISP'(1) << idx);
      sseg <= HEX7SEG[digits[4*int'(idx) +: 4]];
    end
  end

endmodule

// File: rtl/scroll_banner_ctrl.sv
// Scrolling hex banner: message register, scroll prescaler, wrap/bounce
// position FSM and window selection feeding the display multiplexer.
module scroll_banner_ctrl
  import banner_pkg::*;
#(
  parameter int N_MSG       = 10,
  parameter int N_DISP      = 4,
  parameter int TICK_DIV    = 25_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                 clk,
  input  logic                 reset,
  scroll_banner_ctrl_if.slave  bus
);

  localparam int PW = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMAX  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PLAST = PW'(N_MSG - 1);
  localparam logic [PW-1:0] PMAX  = PW'(N_MSG - N_DISP);

  localparam logic [0:0] BDIR_UP   = 1'b0;
  localparam logic [0:0] BDIR_DOWN = 1'b1;

  if (N_MSG < N_DISP) begin : g_bad_nmsg
    $error("scroll_banner_ctrl: N_MSG must be >= N_DISP");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("scroll_banner_ctrl: TICK_DIV must be >= 2");
  end

  logic [4*N_MSG-1:0]  msg_reg;
  logic [TW-1:0]       presc;
  logic [PW-1:0]       pos;
  logic [0:0]          bdir;
  logic [PW-1:0]       pos_nxt;
  logic [0:0]          bdir_nxt;
  logic                tick;
  logic [4*N_DISP-1:0] window;

  // A load in the same cycle suppresses the step.
  assign tick = bus.en && (presc == TMAX) && !bus.load;

  // Message capture and scroll prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_reg <= '0;
      presc   <= '0;
    end else if (bus.load) begin
      msg_reg <= bus.msg;
      presc   <= '0;
    end else if (bus.en) begin
      presc <= (presc == TMAX) ? '0 : presc + 1'b1;
    end
  end

  // Next scroll position for wrap and bounce modes.
  always_comb begin
    pos_nxt  = pos;
    bdir_nxt = bdir;
    if (bus.mode == MODE_WRAP) begin
      if (bus.dir) pos_nxt = (pos == '0)    ? PLAST : pos - PW'(1);
      else         pos_nxt = (pos == PLAST) ? '0    : pos + PW'(1);
    end else if (PMAX == '0) begin
      pos_nxt = '0;
    end else if (pos > PMAX) begin
      pos_nxt  = PMAX;
      bdir_nxt = BDIR_DOWN;
    end else if (bdir == BDIR_UP) begin
      if (pos == PMAX) begin
        pos_nxt  = PMAX - PW'(1);
        bdir_nxt = BDIR_DOWN;
      end else begin
        pos_nxt = pos + PW'(1);
      end
    end else begin
      if (pos == '0) begin
        pos_nxt  = PW'(1);
        bdir_nxt = BDIR_UP;
      end else begin
        pos_nxt = pos - PW'(1);
      end
    end
  end

  // Position/bounce-direction state, reset to the start by load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= '0;
      bdir <= BDIR_UP;
    end else if (bus.load) begin
      pos  <= '0;
      bdir <= BDIR_UP;
    end else if (tick) begin
      pos  <= pos_nxt;
      bdir <= bdir_nxt;
    end
  end

  // Display digit i shows message digit (pos+i) mod N_MSG; pos < N_MSG and
  // i < N_DISP <= N_MSG, so a single subtraction is enough for the modulo.
  always_comb begin
    int unsigned k;
    window = '0;
    k      = 0;
    for (int unsigned i = 0; i < N_DISP; i++) begin
      k = 32'(pos) + i;
      if (k >= 32'(N_MSG)) k = k - 32'(N_MSG);
      window[4*i +: 4] = msg_reg[4*k +: 4];
    end
  end

  assign bus.pos         = pos;
  assign bus.scroll_tick = tick;

  sseg_mux_drv #(
    .N_DISP      (N_DISP),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_mux (
    .clk    (clk),
    .reset  (reset),
    .digits (window),
    .an     (bus.an),
    .sseg   (bus.sseg)
  );

endmodule

// File: tb/tb_scroll_banner_ctrl.sv
// Directed bench for scroll_banner_ctrl with a short message and fast
// prescalers so every scroll and multiplex corner is reached quickly.
module tb_scroll_banner_ctrl;

  localparam int N_MSG       = 6;
  localparam int N_DISP      = 4;
  localparam int TICK_DIV    = 4;
  localparam int REFRESH_DIV = 2;

  logic clk;
  logic reset;

  scroll_banner_ctrl_if #(.N_MSG(N_MSG), .N_DISP(N_DISP)) bus ();

  scroll_banner_ctrl #(
    .N_MSG       (N_MSG),
    .N_DISP      (N_DISP),
    .TICK_DIV    (TICK_DIV),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic       en;
    logic       dir;
    logic       mode;
    logic [2:0] pos;
  } vec_t;

  vec_t vecs [20];

  // Apply one scroll vector: wait for the next tick, check the tick spacing,
  // then check the position registered on that tick.
  task automatic apply_vec(input int i);
    int n;
    bus.en   = vecs[i].en;
    bus.dir  = vecs[i].dir;
    bus.mode = vecs[i].mode;
    #1;
    n = 0;
    while (!bus.scroll_tick && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("vec%0d_tick_gap", i), bus.scroll_tick ? n + 1 : -1, TICK_DIV);
    @(negedge clk);
    chk($sformatf("vec%0d_pos", i), int'(bus.pos), int'(vecs[i].pos));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  // Wait (bounded) for a given anode pattern, then check the segments.
  task automatic hunt(input string nm, input logic [3:0] want, input logic [6:0] exp);
    int n;
    n = 0;
    while (bus.an !== want && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (bus.an !== want) chk({nm, "_an"}, int'(bus.an), int'(want));
    else                 chk(nm, int'(bus.sseg), int'(exp));
  endtask

  logic [3:0] t1_an [8];
  logic [6:0] t1_ss [8];

  initial begin
    int ticks;
    int trans;
    int n;
    logic [3:0] prev;

    t1_an = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    t1_ss = '{7'h40, 7'h79, 7'h24, 7'h24, 7'h30, 7'h30, 7'h19, 7'h19};

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd5};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'd2};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd3};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 3'd4};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd5};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 3'd2};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 3'd1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 3'd2};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 3'd3};

    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.dir  = 1'b0;
    bus.mode = 1'b0;
    bus.load = 1'b1;
    bus.msg  = 24'h654321;

    // Reset held: blank display, position zero, load ignored.
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", int'(bus.an), 4'hF);
    chk("rst_sseg", int'(bus.sseg), 7'h7F);
    chk("rst_pos", int'(bus.pos), 0);
    chk("rst_tick", int'(bus.scroll_tick), 0);

    // Release with load pending: anodes step E,D,B,7 every two clocks.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk($sformatf("mux%0d_an", k), int'(bus.an), int'(t1_an[k]));
      chk($sformatf("mux%0d_sseg", k), int'(bus.sseg), int'(t1_ss[k]));
    end

    // Wrap forward up to pos=5, then freeze and inspect the wrapped window.
    run_vecs(0, 4);
    bus.en = 1'b0;
    @(negedge clk);
    hunt("win5_d0", 4'hE, 7'h02);
    hunt("win5_d1", 4'hD, 7'h79);

    // Wrap forward 5->0, then backward 0->5.
    run_vecs(5, 6);

    // Prescaler frozen: no ticks, position held, refresh keeps going.
    bus.en = 1'b0;
    ticks  = 0;
    trans  = 0;
    prev   = bus.an;
    repeat (20) begin
      @(negedge clk);
      if (bus.scroll_tick) ticks++;
      if (bus.an != prev) trans++;
      prev = bus.an;
    end
    chk("freeze_ticks", ticks, 0);
    chk("freeze_pos", int'(bus.pos), 5);
    chk("freeze_refresh", int'(trans >= 9), 1);

    // Bounce from a fresh load, then wrap to 5 and re-enter bounce.
    bus.mode = 1'b1;
    bus.en   = 1'b1;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("bounce_load_pos", int'(bus.pos), 0);
    run_vecs(7, 17);

    // Load coinciding with a tick at pos=3 wins and suppresses the tick.
    run_vecs(18, 19);
    n = 0;
    while (!bus.scroll_tick && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("pre_load_tick", int'(bus.scroll_tick), 1);
    bus.msg  = 24'hABCDEF;
    bus.load = 1'b1;
    #1;
    chk("load_tick_suppressed", int'(bus.scroll_tick), 0);
    @(negedge clk);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    chk("load_pos", int'(bus.pos), 0);
    @(negedge clk);
    hunt("load_d0", 4'hE, 7'h0E);
    hunt("load_d3", 4'h7, 7'h46);

    // Asynchronous reset pulse between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_an", int'(bus.an), 4'hF);
    chk("arst_sseg", int'(bus.sseg), 7'h7F);
    chk("arst_pos", int'(bus.pos), 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    hunt("arst_msg_d0", 4'hE, 7'h40);
    hunt("arst_msg_d2", 4'hB, 7'h40);
    chk("arst_pos_after", int'(bus.pos), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
